// File: rtl/sized_data_memory_if.sv
// Request/response bundle for the sized data memory.
// The master issues loads and stores; the slave returns registered results.
interface sized_data_memory_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic [ADDR_W-1:0] Add;
  logic              MemWrite;
  logic              MemRead;
  logic [1:0]        Size;
  logic              Unsigned;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;
  logic              ReadValid;
  logic              Error;

  modport master (
    output Add, MemWrite, MemRead,
    output Size, Unsigned, WriteData,
    input  ReadData, ReadValid, Error
  );

  modport slave (
    input  Add, MemWrite, MemRead,
    input  Size, Unsigned, WriteData,
    output ReadData, ReadValid, Error
  );
endinterface

// File: rtl/sized_data_memory.sv
// Flop-based doubleword memory with byte/half/word/double accesses.
// Loads complete in one cycle; bad or conflicting requests pulse Error.
module sized_data_memory #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 64
) (
  input logic clk,
  input logic reset,
  sized_data_memory_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT =
    ADDR_W'(DEPTH) << 3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_RSP,
    ERR_RSP
  } state_t;

  state_t state, stateNext;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] readDataQ;
  logic [DATA_W-1:0] rdShift;
  logic [DATA_W-1:0] wrShift;
  logic [DATA_W-1:0] loadVal;
  logic [IDX_W-1:0]  idx;
  logic [2:0]        offset;
  logic [7:0]        sizeMask;
  logic [7:0]        byteMask;
  logic              misaligned;
  logic              outOfRange;
  logic              addrOk;
  logic              doStore;
  logic              doLoad;
  logic              doErr;
  logic              signFill;

  assign offset = bus.Add[2:0];
  assign idx    = bus.Add[IDX_W+2:3];

  always_comb begin
    misaligned = 1'b0;
    sizeMask   = 8'h01;
    unique case (bus.Size)
      2'b00: begin
        misaligned = 1'b0;
        sizeMask   = 8'h01;
      end
      2'b01: begin
        misaligned = bus.Add[0];
        sizeMask   = 8'h03;
      end
      2'b10: begin
        misaligned = |bus.Add[1:0];
        sizeMask   = 8'h0F;
      end
      2'b11: begin
        misaligned = |bus.Add[2:0];
        sizeMask   = 8'hFF;
      end
    endcase
  end

  assign outOfRange = bus.Add >= ADDR_LIMIT;
  assign addrOk     = !misaligned && !outOfRange;
  assign doStore    = bus.MemWrite && addrOk;
  assign doLoad     = bus.MemRead && !bus.MemWrite && addrOk;
  // Conflicting write+read still stores, but flags the dropped load.
  assign doErr      = (bus.MemWrite || bus.MemRead) &&
                      (!addrOk || (bus.MemWrite && bus.MemRead));

  assign byteMask = sizeMask << offset;
  assign wrShift  = bus.WriteData << {offset, 3'b000};
  assign rdShift  = mem[idx] >> {offset, 3'b000};

  always_comb begin
    loadVal  = rdShift;
    signFill = 1'b0;
    unique case (bus.Size)
      2'b00: begin
        signFill = !bus.Unsigned && rdShift[7];
        loadVal  = {{(DATA_W-8){signFill}}, rdShift[7:0]};
      end
      2'b01: begin
        signFill = !bus.Unsigned && rdShift[15];
        loadVal  = {{(DATA_W-16){signFill}}, rdShift[15:0]};
      end
      2'b10: begin
        signFill = !bus.Unsigned && rdShift[31];
        loadVal  = {{(DATA_W-32){signFill}}, rdShift[31:0]};
      end
      2'b11: begin
        signFill = 1'b0;
        loadVal  = rdShift;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (doStore) begin
      for (int b = 0; b < 8; b++)
        if (byteMask[b])
          mem[idx][8*b +: 8] <= wrShift[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readDataQ <= '0;
    else if (doLoad) readDataQ <= loadVal;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= stateNext;
  end

  always_comb begin
    stateNext = IDLE;
    unique case (1'b1)
      doLoad:  stateNext = LOAD_RSP;
      doErr:   stateNext = ERR_RSP;
      default: stateNext = IDLE;
    endcase
  end

  assign bus.ReadData  = readDataQ;
  assign bus.ReadValid = (state == LOAD_RSP);
  assign bus.Error     = (state == ERR_RSP);
endmodule

// File: tb/tb_sized_data_memory.sv
// Bench for sized_data_memory: directed vector table, reset
// corner sequence, and random traffic against a byte-array model.
module tb_sized_data_memory;
  localparam int DEPTH = 256;
  localparam int NBYTE = DEPTH * 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  sized_data_memory_if #(.DATA_W(64), .ADDR_W(64)) bus ();

  sized_data_memory #(
    .DATA_W(64),
    .DEPTH (DEPTH),
    .ADDR_W(64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [1:0]  sz;
    logic        un;
    logic [63:0] ad;
    logic [63:0] wd;
    logic [63:0] eD;
    logic        eV;
    logic        eE;
  } vec_t;

  vec_t vecs [24];

  logic [7:0]  mB [NBYTE];
  logic [63:0] lastRd;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic apply(input string nm,
                       input logic we, input logic re,
                       input logic [1:0] sz, input logic un,
                       input logic [63:0] ad,
                       input logic [63:0] wd,
                       input logic [63:0] eD,
                       input logic eV, input logic eE);
    bus.MemWrite  = we;
    bus.MemRead   = re;
    bus.Size      = sz;
    bus.Unsigned  = un;
    bus.Add       = ad;
    bus.WriteData = wd;
    @(posedge clk);
    @(negedge clk);
    check({nm, ".data"}, bus.ReadData, eD);
    check({nm, ".valid"}, 64'(bus.ReadValid), 64'(eV));
    check({nm, ".err"}, 64'(bus.Error), 64'(eE));
  endtask

  task automatic idleBus();
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    bus.Size      = 2'b00;
    bus.Unsigned  = 1'b0;
    bus.Add       = '0;
    bus.WriteData = '0;
  endtask

  task automatic doReset(input string nm);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check({nm, ".rst.data"}, bus.ReadData, 64'd0);
    check({nm, ".rst.valid"}, 64'(bus.ReadValid), 64'd0);
    check({nm, ".rst.err"}, 64'(bus.Error), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < NBYTE; i++) mB[i] = 8'h00;
    lastRd = '0;
  endtask

  function automatic logic [63:0] modelLoad(input int ad,
                                            input int sz,
                                            input logic un);
    int          n;
    logic [63:0] v;
    n = 1 << sz;
    v = '0;
    for (int i = 0; i < n; i++)
      v = v | (64'(mB[ad+i]) << (8 * i));
    if (!un && n < 8 && v[8*n-1])
      v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v;
  endfunction

  task automatic fillVecs();
    vecs[0]  = '{0,1,2'd3,0,64'h10,64'h0,64'h0,1,0};
    vecs[1]  = '{1,0,2'd3,0,64'h08,64'h0123456789ABCDEF,
                 64'h0,0,0};
    vecs[2]  = '{0,1,2'd3,0,64'h08,64'h0,
                 64'h0123456789ABCDEF,1,0};
    vecs[3]  = '{1,0,2'd0,0,64'h0B,64'h80,
                 64'h0123456789ABCDEF,0,0};
    vecs[4]  = '{0,1,2'd0,0,64'h0B,64'h0,
                 64'hFFFFFFFFFFFFFF80,1,0};
    vecs[5]  = '{0,1,2'd0,1,64'h0B,64'h0,64'h80,1,0};
    vecs[6]  = '{0,1,2'd3,0,64'h08,64'h0,
                 64'h0123456780ABCDEF,1,0};
    vecs[7]  = '{1,0,2'd1,0,64'h09,64'hFFFF,
                 64'h0123456780ABCDEF,0,1};
    vecs[8]  = '{1,0,2'd3,0,64'h800,64'hFFFFFFFFFFFFFFFF,
                 64'h0123456780ABCDEF,0,1};
    vecs[9]  = '{0,1,2'd3,0,64'h08,64'h0,
                 64'h0123456780ABCDEF,1,0};
    vecs[10] = '{0,1,2'd3,0,64'h00,64'h0,64'h0,1,0};
    vecs[11] = '{1,0,2'd0,0,64'h7FF,64'hA5,64'h0,0,0};
    vecs[12] = '{0,1,2'd0,1,64'h7FF,64'h0,64'hA5,1,0};
    vecs[13] = '{0,1,2'd0,1,64'h800,64'h0,64'hA5,0,1};
    vecs[14] = '{1,1,2'd3,0,64'h20,64'hEFA,64'hA5,0,1};
    vecs[15] = '{0,1,2'd3,0,64'h20,64'h0,64'hEFA,1,0};
    vecs[16] = '{0,0,2'd3,0,64'h20,64'h0,64'hEFA,0,0};
    vecs[17] = '{0,1,2'd1,1,64'h0A,64'h0,64'h80AB,1,0};
    vecs[18] = '{0,1,2'd1,0,64'h0A,64'h0,
                 64'hFFFFFFFFFFFF80AB,1,0};
    vecs[19] = '{0,1,2'd2,0,64'h0C,64'h0,64'h01234567,1,0};
    vecs[20] = '{0,1,2'd2,0,64'h0E,64'h0,64'h01234567,0,1};
    vecs[21] = '{0,1,2'd2,0,64'h08,64'h0,
                 64'hFFFFFFFF80ABCDEF,1,0};
    vecs[22] = '{0,1,2'd2,1,64'h08,64'h0,64'h80ABCDEF,1,0};
    vecs[23] = '{0,1,2'd3,1,64'h08,64'h0,
                 64'h0123456780ABCDEF,1,0};
  endtask

  task automatic randomPhase(input int iters);
    logic        we, re, un, ok;
    logic [1:0]  sz;
    int          ad, n;
    logic [63:0] wd, eD;
    logic        eV, eE;
    for (int k = 0; k < iters; k++) begin
      we = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 9) == 0) begin
        we = 1'b1;
        re = 1'b1;
      end
      sz = 2'($urandom_range(0, 3));
      un = 1'($urandom_range(0, 1));
      n  = 1 << sz;
      if ($urandom_range(0, 7) == 0)
        ad = int'($urandom_range(NBYTE - 16, NBYTE + 40));
      else
        ad = int'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) ad = ad & ~(n - 1);
      wd = {$urandom, $urandom};
      ok = (ad % n == 0) && (ad < NBYTE);
      eV = re && !we && ok;
      eE = (we || re) && (!ok || (we && re));
      if (eV) lastRd = modelLoad(ad, int'(sz), un);
      eD = lastRd;
      if (we && ok)
        for (int i = 0; i < n; i++) mB[ad+i] = wd[8*i +: 8];
      apply($sformatf("rnd%0d", k), we, re, sz, un,
            64'(ad), wd, eD, eV, eE);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idleBus();
    fillVecs();
    doReset("init");

    for (int i = 0; i < 24; i++)
      apply($sformatf("vec%0d", i), vecs[i].we, vecs[i].re,
            vecs[i].sz, vecs[i].un, vecs[i].ad, vecs[i].wd,
            vecs[i].eD, vecs[i].eV, vecs[i].eE);

    // Reset landing in the middle of a load response.
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b1;
    bus.Size     = 2'b11;
    bus.Add      = 64'h08;
    @(posedge clk);
    #1;
    check("midrst.pre.valid", 64'(bus.ReadValid), 64'd1);
    check("midrst.pre.data", bus.ReadData,
          64'h0123456780ABCDEF);
    #1 reset = 1'b1;
    #1;
    check("midrst.valid", 64'(bus.ReadValid), 64'd0);
    check("midrst.data", bus.ReadData, 64'd0);
    check("midrst.err", 64'(bus.Error), 64'd0);
    bus.MemWrite  = 1'b1;
    bus.MemRead   = 1'b0;
    bus.WriteData = 64'h5555AAAA5555AAAA;
    @(posedge clk);
    @(negedge clk);
    check("rsthold.valid", 64'(bus.ReadValid), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < NBYTE; i++) mB[i] = 8'h00;
    apply("postrst.idle", 0, 0, 2'd3, 0, 64'h08, 64'h0,
          64'h0, 0, 0);
    apply("postrst.ld", 0, 1, 2'd3, 0, 64'h08, 64'h0,
          64'h0, 1, 0);

    doReset("rnd");
    randomPhase(400);
    idleBus();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sized_data_memory.md
SIZED_DATA_MEMORY -- requirements
Module: sized_data_memory

Interface
REQ-001 Parameter DATA_W, default 64: data width in bits; the only supported value is 64.
REQ-002 Parameter DEPTH, default 256: number of DATA_W-bit doublewords; a power of two, at least 2.
REQ-003 Parameter ADDR_W, default 64: byte-address width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 Add  input  ADDR_W  byte address of the access.
REQ-007 MemWrite  input  1  store request, sampled at the rising edge.
REQ-008 MemRead  input  1  load request, sampled at the rising edge.
REQ-009 Size  input  2  access size: 00 byte, 01 half, 10 word, 11 double.
REQ-010 Unsigned  input  1  load extension: 1 zero-extend, 0 sign-extend.
REQ-011 WriteData  input  DATA_W  store data, right-aligned (the low 8·2^Size bits are used).
REQ-012 ReadData  output  DATA_W  registered load result, right-aligned and extended.
REQ-013 ReadValid  output  1  one-cycle pulse: ReadData holds a new result.
REQ-014 Error  output  1  one-cycle pulse: the previous request was rejected or in conflict.

Function
REQ-015 Storage SHALL be DEPTH×DATA_W flops, little-endian: index = Add[log2(DEPTH)+2:3], byte offset = Add[2:0].
REQ-016 Access SHALL be aligned when Add mod 2^Size == 0; otherwise it is misaligned.
REQ-017 Access SHALL be out of range when Add ≥ DEPTH·8; the address never wraps.
REQ-018 A valid store SHALL update only bytes offset..offset+2^Size−1 at the sampling edge; all other bytes are unchanged.
REQ-019 A valid load SHALL register ReadData and pulse ReadValid at the sampling edge, so the result is visible for exactly one cycle after the request edge (latency 1).
REQ-020 Load extension: Unsigned=1 SHALL fill the upper bits with 0; Unsigned=0 SHALL replicate the MSB of the accessed field; Size=11 SHALL ignore Unsigned.
REQ-021 ReadData SHALL hold its last value when no valid load occurs; ReadValid SHALL be 0 in every cycle without a valid load.
REQ-022 A misaligned or out-of-range request SHALL neither modify memory nor pulse ReadValid; Error SHALL pulse 1 for one cycle; ReadData SHALL hold.
REQ-023 When MemWrite=1 and MemRead=1 together with a valid address, the store SHALL be performed, the load dropped, ReadValid=0 and Error pulsed.
REQ-024 A load at edge N+1 following a store at edge N to the same bytes SHALL return the stored data.
REQ-025 Control FSM states: IDLE, LOAD_RSP, ERR_RSP.
- From any state: valid load → LOAD_RSP; rejected or conflict → ERR_RSP; otherwise → IDLE.
- ReadValid = (state == LOAD_RSP); Error = (state == ERR_RSP).
REQ-026 Back-to-back requests SHALL be accepted every cycle with no stall.

Reset
REQ-027 While reset=1: all memory bytes = 0, ReadData = 0, ReadValid = 0, Error = 0, state = IDLE, asynchronously.
REQ-028 A request sampled while reset=1 SHALL be ignored.
REQ-029 Reset asserted during LOAD_RSP SHALL drop ReadValid immediately; no result is delivered after release.

Verification
REQ-030 Reset, then load double at 0x10 → ReadData=0, ReadValid=1 for one cycle, Error=0.
REQ-031 Store double 0x0123456789ABCDEF at 0x08, then load double at 0x08 on the next edge → 0x0123456789ABCDEF, ReadValid=1.
REQ-032 Store byte 0x80 at 0x0B, then:
- signed byte load at 0x0B → 0xFFFFFFFFFFFFFF80;
- unsigned byte load at 0x0B → 0x0000000000000080;
- double load at 0x08 → 0x0123456780ABCDEF.
REQ-033 Half store at 0x09, then store at 0x800 with DEPTH=256 → Error pulses each time, ReadValid=0; memory at 0x08 and at 0x000 unchanged.
REQ-034 MemWrite=MemRead=1, double 0xEFA at 0x20 → Error=1, ReadValid=0; a following load at 0x20 returns 0xEFA.
REQ-035 Load at 0x08 with reset asserted mid-cycle → ReadValid=0 and ReadData=0 at once; a load after release returns 0.
